// File: rtl/verdict_tx_queue_pkg.sv
// Shared FSM encodings and default sizing for the verdict transmit queue.
package verdict_tx_queue_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam int DEF_DEPTH   = 4;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TMO_CYC = 1024;

endpackage

// File: rtl/verdict_tx_queue_fifo.sv
// 1-bit verdict FIFO; pointers carry an extra wrap bit to tell full from empty.
module verdict_fifo
    import verdict_tx_queue_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [DEPTH-1:0] mem_q, mem_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign dout  = mem_q[rd_q[AW-1:0]];

    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_q[AW-1:0]] = din;
            wr_d = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            mem_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/verdict_tx_queue.sv
// Queues per-packet verdicts and hands them to the host over tx_init/tx_ok,
// with saturating packet/drop counters and sticky overflow/timeout flags.
module verdict_tx_queue
    import verdict_tx_queue_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TMO_CYC = DEF_TMO_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             done,
    input  logic             drop,
    input  logic             tx_ok,
    output logic             tx_init,
    output logic [2:0]       tx_drop,
    output logic             busy,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             overflow,
    output logic             timeout
);

    localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

    state_t           state_q, state_d;
    logic             verdict_q, verdict_d;
    logic             tx_init_q, tx_init_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [CNT_W-1:0] pkt_q, pkt_d;
    logic [CNT_W-1:0] drp_q, drp_d;
    logic             ovf_q, ovf_d;
    logic             to_q, to_d;

    logic fifo_pop;
    logic fifo_dout;
    logic fifo_full;
    logic fifo_empty;

    assign fifo_pop = (state_q == IDLE) && !fifo_empty;

    verdict_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (done),
        .pop  (fifo_pop),
        .din  (drop),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        verdict_d = verdict_q;
        tx_init_d = 1'b0;
        tmo_d     = tmo_q;
        to_d      = to_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d   = SEND;
                    verdict_d = fifo_dout;
                    tx_init_d = 1'b1;
                end
            end
            SEND: begin
                state_d = WAIT;
                tmo_d   = '0;
            end
            WAIT: begin
                if (tx_ok) begin
                    state_d = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                    to_d    = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counters see every verdict, including ones the FIFO could not hold.
    always_comb begin
        pkt_d = pkt_q;
        drp_d = drp_q;
        ovf_d = ovf_q;
        if (done) begin
            if (pkt_q != '1) pkt_d = pkt_q + 1'b1;
            if (drop && drp_q != '1) drp_d = drp_q + 1'b1;
            if (fifo_full && !fifo_pop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            verdict_q <= 1'b0;
            tx_init_q <= 1'b0;
            tmo_q     <= '0;
            pkt_q     <= '0;
            drp_q     <= '0;
            ovf_q     <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            verdict_q <= verdict_d;
            tx_init_q <= tx_init_d;
            tmo_q     <= tmo_d;
            pkt_q     <= pkt_d;
            drp_q     <= drp_d;
            ovf_q     <= ovf_d;
            to_q      <= to_d;
        end
    end

    assign tx_init    = tx_init_q;
    assign tx_drop    = {3{verdict_q}};
    assign busy       = (state_q != IDLE) || !fifo_empty;
    assign pkt_count  = pkt_q;
    assign drop_count = drp_q;
    assign overflow   = ovf_q;
    assign timeout    = to_q;

endmodule

// File: tb/tb_verdict_tx_queue.sv
// Bench for verdict_tx_queue: cycle table, scoreboarded verdict stream, corner sequences.
module tb_verdict_tx_queue;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          done = 1'b0;
    logic          drop = 1'b0;
    logic          tx_ok = 1'b0;
    logic          tx_init;
    logic [2:0]    tx_drop;
    logic          busy;
    logic [CW-1:0] pkt_count;
    logic [CW-1:0] drop_count;
    logic          overflow;
    logic          timeout;

    verdict_tx_queue #(
        .DEPTH  (4),
        .CNT_W  (CW),
        .TMO_CYC(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .done      (done),
        .drop      (drop),
        .tx_ok     (tx_ok),
        .tx_init   (tx_init),
        .tx_drop   (tx_drop),
        .busy      (busy),
        .pkt_count (pkt_count),
        .drop_count(drop_count),
        .overflow  (overflow),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;
    bit   exp_q[$];
    int   init_cyc[$];
    bit   sb_en = 1'b1;
    logic prev_init = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: each tx_init pulse must carry the oldest expected verdict.
    always @(negedge clk) begin
        bit e;
        if (!rst && tx_init) begin
            init_cyc.push_back(cyc);
            if (sb_en) begin
                e = (exp_q.size() > 0) ? exp_q[0] : 1'b0;
                nvec++;
                if (prev_init || exp_q.size() == 0 || tx_drop !== {3{e}}) begin
                    nerr++;
                    $display("FAIL tx_verdict: got txd=%b prev_init=%b pending=%0d, want txd=%b",
                             tx_drop, prev_init, exp_q.size(), {3{e}});
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end
        prev_init = tx_init;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        done  = 1'b0;
        drop  = 1'b0;
        tx_ok = 1'b0;
        tick();
        exp_q.delete();
        init_cyc.delete();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic pulse(bit d, bit accepted);
        done = 1'b1;
        drop = d;
        if (accepted) exp_q.push_back(d);
        tick();
        done = 1'b0;
        drop = 1'b0;
    endtask

    task automatic wait_idle(string nm, int max);
        int i = 0;
        while (busy && i < max) begin
            tick();
            i++;
        end
        chk(nm, busy, 0);
    endtask

    typedef struct {
        logic          done;
        logic          drop;
        logic          ok;
        logic          init;
        logic [2:0]    txd;
        logic          busy;
        logic [CW-1:0] pkt;
        logic [CW-1:0] dc;
    } vec_t;

    vec_t tbl[6];

    initial begin
        // done, drop, tx_ok -> tx_init, tx_drop, busy, pkt, drop_count
        tbl[0] = '{1, 1, 0, 0, 3'b000, 1, 1, 1};
        tbl[1] = '{0, 0, 1, 1, 3'b111, 1, 1, 1};
        tbl[2] = '{0, 0, 1, 0, 3'b111, 1, 1, 1};
        tbl[3] = '{0, 0, 0, 0, 3'b111, 1, 1, 1};
        tbl[4] = '{0, 0, 1, 0, 3'b111, 0, 1, 1};
        tbl[5] = '{0, 0, 0, 0, 3'b111, 0, 1, 1};

        tick();
        chk("rst_tx_init", tx_init, 0);
        chk("rst_tx_drop", tx_drop, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pkt", pkt_count, 0);
        chk("rst_flags", {overflow, timeout}, 0);

        // 1: single verdict, cycle by cycle
        do_reset();
        exp_q.push_back(1'b1);
        for (int i = 0; i < 6; i++) begin
            done  = tbl[i].done;
            drop  = tbl[i].drop;
            tx_ok = tbl[i].ok;
            tick();
            chk($sformatf("t1_init[%0d]", i), tx_init, tbl[i].init);
            chk($sformatf("t1_txd[%0d]", i), tx_drop, tbl[i].txd);
            chk($sformatf("t1_busy[%0d]", i), busy, tbl[i].busy);
            chk($sformatf("t1_pkt[%0d]", i), pkt_count, tbl[i].pkt);
            chk($sformatf("t1_dc[%0d]", i), drop_count, tbl[i].dc);
        end
        done  = 1'b0;
        tx_ok = 1'b0;

        // 2: burst with immediate acknowledge
        do_reset();
        tx_ok = 1'b1;
        pulse(1, 1);
        pulse(0, 1);
        pulse(1, 1);
        pulse(0, 1);
        wait_idle("t2_drain", 40);
        chk("t2_pulses", init_cyc.size(), 4);
        if (init_cyc.size() == 4) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("t2_gap[%0d]", i), init_cyc[i+1] - init_cyc[i], 3);
            end
        end
        chk("t2_overflow", overflow, 0);
        chk("t2_pkt", pkt_count, 4);
        chk("t2_dc", drop_count, 2);
        chk("t2_sb_empty", exp_q.size(), 0);

        // 3: overflow with host stalled
        do_reset();
        tx_ok = 1'b0;
        pulse(1, 1);
        pulse(0, 1);
        pulse(0, 1);
        pulse(1, 1);
        pulse(1, 1);
        pulse(0, 0);
        tick();
        tick();
        chk("t3_pulses", init_cyc.size(), 1);
        chk("t3_overflow", overflow, 1);
        chk("t3_pkt", pkt_count, 6);
        chk("t3_dc", drop_count, 3);
        tx_ok = 1'b1;
        wait_idle("t3_drain", 60);
        chk("t3_pulses_all", init_cyc.size(), 5);
        chk("t3_sb_empty", exp_q.size(), 0);

        // 4: handshake timeout, then the queued verdict goes out
        do_reset();
        tx_ok = 1'b0;
        pulse(1, 1);
        pulse(0, 1);
        repeat (8) tick();
        chk("t4_no_timeout_yet", timeout, 0);
        for (int i = 0; i < 60 && init_cyc.size() < 2; i++) tick();
        chk("t4_pulses", init_cyc.size(), 2);
        if (init_cyc.size() >= 2) chk("t4_gap", init_cyc[1] - init_cyc[0], 18);
        chk("t4_timeout", timeout, 1);
        tx_ok = 1'b1;
        wait_idle("t4_drain", 20);

        // 5: push while full in the cycle the FSM pops
        do_reset();
        tx_ok = 1'b0;
        pulse(0, 1);
        pulse(1, 1);
        pulse(1, 1);
        pulse(0, 1);
        pulse(1, 1);
        tx_ok = 1'b1;
        tick();
        tx_ok = 1'b0;
        pulse(1, 1);
        chk("t5_overflow", overflow, 0);
        chk("t5_pkt", pkt_count, 6);
        chk("t5_dc", drop_count, 4);
        tx_ok = 1'b1;
        wait_idle("t5_drain", 60);
        chk("t5_pulses", init_cyc.size(), 6);
        chk("t5_sb_empty", exp_q.size(), 0);

        // 6: asynchronous reset in the middle of WAIT
        do_reset();
        tx_ok = 1'b0;
        pulse(1, 1);
        pulse(0, 1);
        pulse(1, 1);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("t6_txd", tx_drop, 0);
        chk("t6_busy", busy, 0);
        chk("t6_cnt", {pkt_count, drop_count}, 0);
        chk("t6_flags", {tx_init, overflow, timeout}, 0);
        exp_q.delete();
        tick();
        init_cyc.delete();
        rst = 1'b0;
        repeat (10) tick();
        chk("t6_quiet", init_cyc.size(), 0);
        chk("t6_idle", busy, 0);
        pulse(0, 1);
        for (int i = 0; i < 10 && init_cyc.size() < 1; i++) tick();
        chk("t6_new_pulse", init_cyc.size(), 1);
        tx_ok = 1'b1;
        wait_idle("t6_drain", 20);

        // 7: counter saturation
        do_reset();
        sb_en = 1'b0;
        tx_ok = 1'b1;
        repeat (20) pulse(1, 0);
        chk("t7_pkt", pkt_count, 15);
        chk("t7_dc", drop_count, 15);
        chk("t7_overflow", overflow, 1);
        pulse(0, 0);
        chk("t7_pkt_hold", pkt_count, 15);
        chk("t7_dc_hold", drop_count, 15);
        wait_idle("t7_drain", 60);
        sb_en = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
